// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width, default rates
// and the tick divider helper used by the receiver and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_state_e;

  localparam int DATA_BITS          = 8;
  localparam int CLK_FREQ_DEFAULT   = 100_000_000;
  localparam int BAUD_RATE_DEFAULT  = 9600;

  function automatic int tick_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider: tick is high for one clk every DIV clocks.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, one-clk data_valid per good byte.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting around each bit centre.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_DEFAULT,
  parameter int BAUD_RATE  = BAUD_RATE_DEFAULT,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 rx_busy,
  output logic                 frame_error
);

  localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SCW      = $clog2(OVERSAMPLE);

`ifdef UART_RX_MAJORITY_EN
  // Majority decisions land one tick after the nominal centre.
  localparam logic [SCW-1:0] START_LAST = SCW'(OVERSAMPLE / 2);
`else
  localparam logic [SCW-1:0] START_LAST = SCW'(OVERSAMPLE / 2 - 1);
`endif
  localparam logic [SCW-1:0] BIT_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic                 tick;
  logic                 sample_bit;
  uart_state_e          state_q;
  logic [SCW-1:0]       sample_cnt_q;
  logic [2:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_out_q;
  logic                 data_valid_q;
  logic                 rx_busy_q;
  logic                 frame_error_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];

  uart_baud_tick #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // Holds rx_s from the two previous ticks (centre-1 and centre at a decision).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= 2'b11;
    end else if (tick) begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign sample_bit = rx_s;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      sample_cnt_q  <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      rx_busy_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      if (tick) begin
        case (state_q)
          IDLE: begin
            if (!rx_s) begin
              state_q      <= START;
              sample_cnt_q <= '0;
            end
          end
          START: begin
            if (sample_cnt_q == START_LAST) begin
              if (sample_bit) begin
                state_q <= IDLE;
              end else begin
                state_q      <= DATA;
                rx_busy_q    <= 1'b1;
                sample_cnt_q <= '0;
                bit_cnt_q    <= '0;
              end
            end else begin
              sample_cnt_q <= sample_cnt_q + SCW'(1);
            end
          end
          DATA: begin
            if (sample_cnt_q == BIT_LAST) begin
              shift_q      <= {sample_bit, shift_q[DATA_BITS-1:1]};
              sample_cnt_q <= '0;
              bit_cnt_q    <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == LAST_BIT) begin
                state_q <= STOP;
              end
            end else begin
              sample_cnt_q <= sample_cnt_q + SCW'(1);
            end
          end
          STOP: begin
            if (sample_cnt_q == BIT_LAST) begin
              rx_busy_q    <= 1'b0;
              sample_cnt_q <= '0;
              if (sample_bit) begin
                data_out_q    <= shift_q;
                data_valid_q  <= 1'b1;
                frame_error_q <= 1'b0;
                state_q       <= IDLE;
              end else begin
                frame_error_q <= 1'b1;
                state_q       <= WAIT_IDLE;
              end
            end else begin
              sample_cnt_q <= sample_cnt_q + SCW'(1);
            end
          end
          WAIT_IDLE: begin
            // A held-low line (break) must go high before a new start is accepted.
            if (rx_s) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign rx_busy     = rx_busy_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 1 Mbaud (96 clk per bit) with a byte scoreboard.
module tb_uart_rx;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int BIT_NS = 960;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       rx_busy;
  logic       frame_error;

  int n_cmp = 0;
  int n_err = 0;
  int n_valid = 0;
  int n_pushed = 0;
  logic [7:0] exp_q[$];

  uart_rx #(
    .BAUD_RATE (1_000_000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .rx_busy     (rx_busy),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
  endtask

  task automatic push_exp(input logic [7:0] b);
    exp_q.push_back(b);
    n_pushed++;
    $display("tx  frame 0x%02h queued", b);
  endtask

  task automatic wait_drain(input int max_clks);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_clks) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: every data_valid pulse pops one expected byte.
  always begin
    @(posedge clk);
    #1;
    if (!reset && data_valid) begin
      n_valid++;
      $display("rx  data_valid data_out=0x%02h frame_error=%0b", data_out, frame_error);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        chk("data_out", data_out, exp_q.pop_front());
      end
      chk("fe_at_valid", frame_error, 0);
    end
  end

  initial begin
    bit busy_seen;

    repeat (5) @(posedge clk);
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_fe", frame_error, 0);
    @(negedge clk);
    reset = 1'b0;
    #(2 * BIT_NS);

    // Two good frames
    push_exp(8'h55);
    send_frame(8'h55, 1'b1, BIT_NS);
    chk("fe_after_55", frame_error, 0);
    push_exp(8'hA5);
    send_frame(8'hA5, 1'b1, BIT_NS);
    wait_drain(200);
    chk("fe_after_A5", frame_error, 0);
    #(BIT_NS);

    // Short glitch of 3 ticks (18 clk) must be rejected
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (18) @(posedge clk);
    rx = 1'b1;
    for (int i = 0; i < 2 * 96; i++) begin
      @(negedge clk);
      if (rx_busy) busy_seen = 1'b1;
    end
    chk("glitch_busy", busy_seen, 0);
    chk("glitch_data_out", data_out, 8'hA5);
    $display("glitch done busy_seen=%0b", busy_seen);

    // Bad stop bit, line held low two more bit times
    send_frame(8'hC3, 1'b0, BIT_NS);
    #(2 * BIT_NS);
    chk("fe_set", frame_error, 1);
    chk("data_held", data_out, 8'hA5);
    $display("bad frame 0xC3 frame_error=%0b data_out=0x%02h", frame_error, data_out);
    rx = 1'b1;
    #(2 * BIT_NS);
    chk("fe_sticky", frame_error, 1);
    push_exp(8'h3C);
    send_frame(8'h3C, 1'b1, BIT_NS);
    wait_drain(200);
    chk("fe_cleared", frame_error, 0);
    #(BIT_NS);

    // Back-to-back frames, no idle gap
    push_exp(8'h00);
    push_exp(8'hFF);
    push_exp(8'h81);
    send_frame(8'h00, 1'b1, BIT_NS);
    send_frame(8'hFF, 1'b1, BIT_NS);
    send_frame(8'h81, 1'b1, BIT_NS);
    wait_drain(200);
    chk("fe_b2b", frame_error, 0);
    #(BIT_NS);

    // Reset in the middle of data bit 4 of 0x96
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'h96 >> i);
      #(BIT_NS);
    end
    rx = 1'b1;
    #(BIT_NS / 2);
    chk("busy_mid_frame", rx_busy, 1);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_data_out", data_out, 0);
    chk("midrst_valid", data_valid, 0);
    chk("midrst_busy", rx_busy, 0);
    chk("midrst_fe", frame_error, 0);
    @(negedge clk);
    reset = 1'b0;
    #(2 * BIT_NS);
    push_exp(8'h96);
    send_frame(8'h96, 1'b1, BIT_NS);
    wait_drain(200);
    #(BIT_NS);

    // Baud mismatch: +2.5% and -2.5% bit period
    push_exp(8'h5A);
    send_frame(8'h5A, 1'b1, BIT_NS + BIT_NS / 40);
    wait_drain(200);
    #(BIT_NS);
    push_exp(8'h5A);
    send_frame(8'h5A, 1'b1, BIT_NS - BIT_NS / 40);
    wait_drain(200);
    #(2 * BIT_NS);

    chk("valid_count", n_valid, n_pushed);
    chk("fe_final", frame_error, 0);
    chk("busy_final", rx_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the companion to the team's uart_tx on the same 100 MHz clock.
- Link format: 8N1, LSB first, line idle high.
- Oversamples the asynchronous rx line at 16x baud, recovers each byte and presents it with a one-cycle data_valid pulse.
- Sits between the board RX pin and the host-side command/data logic.

Parameters:
- CLK_FREQ, 100_000_000: input clock frequency in Hz.
- BAUD_RATE, 9600: line rate in bits/s.
- OVERSAMPLE, 16: ticks per bit; power of two, minimum 8.
- TICK_DIV, CLK_FREQ/(BAUD_RATE*OVERSAMPLE): clocks per tick (651 at defaults); derived, never overridden directly.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  serial input, asynchronous to clk, idle high.
- data_out  out  8  last correctly framed byte; held until the next good byte.
- data_valid  out  1  one-clk pulse when data_out updates.
- rx_busy  out  1  high from confirmed start bit until the end of the stop-bit sample.
- frame_error  out  1  sticky; set on bad stop bit, cleared by the next good byte.

Behaviour:
- Interface (decided): one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values:
  - data_out=0, data_valid=0, rx_busy=0, frame_error=0.
  - Synchroniser flops=1; all counters=0; state=IDLE.
- Synchroniser: 2-flop, giving rx_s; 2-cycle input latency.
- Tick generator: free-running counter 0..TICK_DIV-1; tick is high for one clk when the counter equals TICK_DIV-1. Width is $clog2(TICK_DIV).
- sample_cnt: width $clog2(OVERSAMPLE); advances only on tick. bit_cnt: 3 bits.
- State machine (all transitions on tick only, except reset):
  - IDLE: rx_s==0 on a tick -> START, sample_cnt=0.
  - START: confirm on the (OVERSAMPLE/2)th tick after detection (mid start bit).
    - rx_s==1 there -> IDLE (glitch rejected, no outputs change).
    - Otherwise -> DATA, rx_busy=1, sample_cnt=0, bit_cnt=0.
  - DATA: sample on every OVERSAMPLE-th tick (bit centre); shift right into shift_reg, MSB-in, so the first bit lands in bit 0. After bit_cnt==7 is sampled -> STOP.
  - STOP: sample after OVERSAMPLE ticks, then rx_busy=0.
    - rx_s==1: data_out<=shift_reg; data_valid=1 for the next clk; frame_error<=0; -> IDLE.
    - rx_s==0: frame_error<=1; data_out unchanged; no data_valid; -> WAIT_IDLE.
  - WAIT_IDLE: break/stuck-low guard; -> IDLE on the first tick with rx_s==1. Start detection is impossible until then.
- Latency: data_valid rises 1 clk after the stop-bit centre tick. That is about 9.5 bit times plus 2 synchroniser clks plus at most 1 tick after the start-bit falling edge.
- Start-edge detection jitter is at most 1 tick (1/16 bit); tolerated baud mismatch is about ±3%.
- Back-to-back frames: the next start bit may begin immediately after the stop bit. IDLE is reached at mid stop bit, so no byte is lost.
- data_valid never coincides with frame_error rising.
- No output backpressure: the consumer must accept within one byte time; data_out is overwritten by the next good byte.
- Reset mid-frame: immediate return to the reset values; the partial byte is discarded.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each start/data/stop decision is a 2-of-3 majority of rx_s at ticks centre-1, centre and centre+1. The decision is taken at the centre+1 tick, so every decision point shifts 1 tick later. Frame timing is otherwise unchanged.
- Undefined: single sample at the centre tick.

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, STOP, WAIT_IDLE); DATA_BITS=8; default CLK_FREQ and BAUD_RATE; a tick_div(clk, baud, os) function.
- Sub-module uart_baud_tick (params DIV; ports clk, reset, tick). Natural, and reusable by uart_tx.

Test Plan:
- Bench override BAUD_RATE=1_000_000 gives TICK_DIV=6, i.e. 96 clk/bit.
- Frame 0x55, then 0xA5, correct stop bits -> two data_valid pulses with data_out=0x55 then 0xA5; frame_error=0 throughout.
- rx low for 3 ticks, then high -> no data_valid, rx_busy stays 0, state back to IDLE.
- Frame 0xC3 with stop bit=0, line held low 2 bit times, then frame 0x3C -> frame_error=1, data_out unchanged after the 0xC3 frame. Then data_valid with data_out=0x3C, frame_error=0.
- Back-to-back 0x00, 0xFF, 0x81 with no idle gap -> three pulses with the correct values, no frame_error.
- Assert reset during data bit 4 of 0x96, release, then send 0x96 again -> all outputs at their reset values during reset; exactly one data_valid with 0x96 afterwards.
- Bit period stretched +2.5% and shrunk -2.5% on frame 0x5A -> 0x5A received both times.
